// File: rtl/mem_out_reader.sv
// Read-side sweep controller for the mem_out SRAM bank: issues lockstep row reads, buffers rows
// in a 4-entry FIFO and streams them over valid/ready. Optional macro MEM_OUT_READER_BANK_MASK_EN.
module mem_out_reader #(
    parameter int word_len   = 32,
    parameter int sram_addr  = 8,
    parameter int sram_count = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [sram_addr-1:0]            base_addr,
    input  logic [sram_addr:0]              num_rows,
`ifdef MEM_OUT_READER_BANK_MASK_EN
    input  logic [sram_count-1:0]           bank_en,
`endif
    output logic                            busy,
    output logic                            done,
    output logic [sram_count-1:0]           CEN,
    output logic [sram_count-1:0]           WEN,
    output logic [sram_count*sram_addr-1:0] A,
    input  logic [sram_count*word_len-1:0]  Q,
    output logic [sram_count*word_len-1:0]  out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last
);
    localparam int row_w = sram_count * word_len;
    localparam logic [sram_addr-1:0] addr_one = sram_addr'(1);
    localparam logic [sram_addr:0]   rows_one = (sram_addr + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [sram_addr-1:0]            addr_q, addr_d;
    logic [sram_addr:0]              rows_q, rows_d;
    logic [sram_count-1:0]           mask_q, mask_d;
    logic [sram_count-1:0]           cen_q, cen_d;
    logic [sram_count*sram_addr-1:0] a_q, a_d;
    logic                            iss_q, iss_d, iss_last_q, iss_last_d;
    logic                            cap_q, cap_d, cap_last_q, cap_last_d;
    logic [row_w-1:0]                fifo_data_q [4];
    logic [3:0]                      fifo_last_q;
    logic [1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]                      count_q, count_d;
    logic [3:0]                      in_flight_s;
    logic                            issue_s, push_s, pop_s;
    logic [row_w-1:0]                push_data_s;
    logic [sram_count-1:0]           start_mask_s;

`ifdef MEM_OUT_READER_BANK_MASK_EN
    assign start_mask_s = bank_en;
`else
    assign start_mask_s = {sram_count{1'b1}};
`endif

    // Credit check: rows buffered plus reads in the SRAM pipe; a same-cycle pop is not counted.
    always_comb begin
        in_flight_s = {1'b0, count_q} + {3'b000, iss_q} + {3'b000, cap_q};
        issue_s     = (state_q == ST_READ) && (in_flight_s < 4'd4);
        pop_s       = (count_q != 3'd0) && out_ready;
        push_s      = cap_q;
    end

    // Captured row with disabled banks forced to zero.
    always_comb begin
        push_data_s = {row_w{1'b0}};
        for (int k = 0; k < sram_count; k++) begin
            if (mask_q[k]) begin
                push_data_s[k*word_len +: word_len] = Q[k*word_len +: word_len];
            end else begin
                push_data_s[k*word_len +: word_len] = {word_len{1'b0}};
            end
        end
    end

    // Sweep FSM, SRAM request generation, read pipeline and FIFO pointers.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        rows_d     = rows_q;
        mask_d     = mask_q;
        cen_d      = {sram_count{1'b1}};
        a_d        = a_q;
        iss_d      = 1'b0;
        iss_last_d = 1'b0;
        cap_d      = iss_q;
        cap_last_d = iss_last_q;
        wr_ptr_d   = push_s ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d    = count_q + {2'b00, push_s} - {2'b00, pop_s};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_rows != {(sram_addr + 1){1'b0}}) begin
                        state_d = ST_READ;
                        busy_d  = 1'b1;
                        addr_d  = base_addr;
                        rows_d  = num_rows;
                        mask_d  = start_mask_s;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    cen_d  = ~mask_q;
                    a_d    = {sram_count{addr_q}};
                    iss_d  = 1'b1;
                    addr_d = addr_q + addr_one;
                    rows_d = rows_q - rows_one;
                    if (rows_q == rows_one) begin
                        iss_last_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                // The last-tagged row is always the final one to leave the FIFO.
                if (pop_s && fifo_last_q[rd_ptr_q]) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control, SRAM request and pipeline registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= {sram_addr{1'b0}};
            rows_q     <= {(sram_addr + 1){1'b0}};
            mask_q     <= {sram_count{1'b0}};
            cen_q      <= {sram_count{1'b1}};
            a_q        <= {(sram_count * sram_addr){1'b0}};
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            cap_q      <= 1'b0;
            cap_last_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            rows_q     <= rows_d;
            mask_q     <= mask_d;
            cen_q      <= cen_d;
            a_q        <= a_d;
            iss_q      <= iss_d;
            iss_last_q <= iss_last_d;
            cap_q      <= cap_d;
            cap_last_q <= cap_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= {row_w{1'b0}};
            end
            fifo_last_q <= 4'b0000;
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= push_data_s;
            fifo_last_q[wr_ptr_q] <= cap_last_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign CEN       = cen_q;
    assign WEN       = {sram_count{1'b1}};
    assign A         = a_q;
    assign out_valid = (count_q != 3'd0);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : {row_w{1'b0}};
    assign out_last  = out_valid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_out_reader.sv
// Self-checking bench for mem_out_reader: behavioural SRAM, queue-based row model, random backpressure.
module tb_mem_out_reader;
    localparam int WL = 32;
    localparam int AW = 8;
    localparam int NB = 16;
    localparam int RW = NB * WL;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_rows;
`ifdef MEM_OUT_READER_BANK_MASK_EN
    logic [NB-1:0] bank_en;
`endif
    logic          busy, done, out_valid, out_ready, out_last;
    logic [NB-1:0] CEN, WEN;
    logic [NB*AW-1:0] A;
    logic [RW-1:0] Q, out_data;

    int errors = 0;
    int checks = 0;

    logic [WL-1:0] mem [NB][256];
    logic [WL-1:0] q_r [NB];
    logic [RW-1:0] exp_q [$];
    bit            last_q [$];
    int first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc, done_cnt, issued;

    mem_out_reader dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .num_rows(num_rows),
`ifdef MEM_OUT_READER_BANK_MASK_EN
        .bank_en(bank_en),
`endif
        .busy(busy), .done(done), .CEN(CEN), .WEN(WEN), .A(A), .Q(Q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM bank: samples CEN/A at the edge, data visible the following cycle.
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (CEN[k] === 1'b0) q_r[k] <= mem[k][A[k*AW +: AW]];
        end
    end

    always_comb begin
        Q = '0;
        for (int k = 0; k < NB; k++) Q[k*WL +: WL] = q_r[k];
    end

    task automatic fill_ramp();
        for (int k = 0; k < NB; k++)
            for (int i = 0; i < 256; i++) mem[k][i] = 32'(i + k);
    endtask

    task automatic fill_random();
        for (int k = 0; k < NB; k++)
            for (int i = 0; i < 256; i++) mem[k][i] = $urandom();
    endtask

    task automatic build_model(input logic [7:0] base, input logic [8:0] n, input logic [15:0] en);
        logic [RW-1:0] row;
        logic [7:0] a;
        exp_q.delete();
        last_q.delete();
        for (int r = 0; r < int'(n); r++) begin
            a = base + 8'(r);
            row = '0;
            for (int k = 0; k < NB; k++) if (en[k]) row[k*WL +: WL] = mem[k][a];
            exp_q.push_back(row);
            last_q.push_back(r == int'(n) - 1);
        end
    endtask

    task automatic sweep(input logic [7:0] base, input logic [8:0] n, input logic [15:0] en,
                         input int ready_pct, input int restart_cyc, input bit launched,
                         input bit chain, input logic [7:0] chain_base, input logic [8:0] chain_n);
        logic [RW-1:0] prev_data, row;
        logic prev_stall, prev_last, lst;
        logic [7:0] exp_a;
        int popped, budget;
        build_model(base, n, en);
        first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
        done_cyc = -1; done_cnt = 0; issued = 0; popped = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        if (!launched) begin
            start = 1'b1; base_addr = base; num_rows = n;
`ifdef MEM_OUT_READER_BANK_MASK_EN
            bank_en = en;
`endif
            @(posedge clk); #1;
        end
        budget = 20 * int'(n) + 40;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc == restart_cyc) begin
                start = 1'b1; base_addr = base + 8'd77; num_rows = 9'd3;
`ifdef MEM_OUT_READER_BANK_MASK_EN
                bank_en = ~en;
`endif
            end else begin
                start = 1'b0;
            end
            out_ready = (int'($urandom_range(99)) < ready_pct);
            checks++;
            if (WEN !== 16'hFFFF) begin errors++; $display("FAIL wen: got %h want ffff", WEN); end
            checks++;
            if (((~CEN) & (~en)) !== 16'h0000) begin
                errors++; $display("FAIL cen_masked: CEN %h with bank enable %h", CEN, en);
            end
            if (((~CEN) & en) != 16'h0000) begin
                exp_a = base + 8'(issued);
                checks++;
                if (CEN !== ~en) begin errors++; $display("FAIL cen_pattern: got %h want %h", CEN, ~en); end
                checks++;
                if (A !== {NB{exp_a}}) begin errors++; $display("FAIL addr: got %h want all banks %h", A, exp_a); end
                issued++;
                checks++;
                if (issued - popped > 4 || issued > int'(n)) begin
                    errors++; $display("FAIL credit: issued %0d popped %0d rows %0d", issued, popped, n);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            checks++;
            if (busy !== ((n != 9'd0) && done_cyc < 0)) begin
                errors++; $display("FAIL busy: got %b at cycle %0d", busy, cyc);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    errors++; $display("FAIL stall_hold: valid %b last %b data changed %b", out_valid, out_last, out_data !== prev_data);
                end
            end
            if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL extra_row: unexpected row %h", out_data);
                end else begin
                    row = exp_q.pop_front();
                    lst = last_q.pop_front();
                    if (out_data !== row || out_last !== lst) begin
                        errors++;
                        $display("FAIL row %0d: data %h last %b, want data %h last %b", popped, out_data, out_last, row, lst);
                    end
                end
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                popped++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done_cyc >= 0 && (chain || cyc >= done_cyc + 2)) break;
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL done_count: got %0d want 1 (0 means timeout)", done_cnt); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rows_missing: %0d rows not delivered", exp_q.size()); end
        if (en != 16'h0000) begin
            checks++;
            if (issued != int'(n)) begin errors++; $display("FAIL issued: got %0d want %0d", issued, n); end
        end
        if (n != 9'd0) begin
            checks++;
            if (done_cyc != last_xfer_cyc + 1) begin
                errors++; $display("FAIL done_timing: done at %0d, last row at %0d", done_cyc, last_xfer_cyc);
            end
        end
        if (chain) begin
            start = 1'b1; base_addr = chain_base; num_rows = chain_n;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (CEN !== 16'hFFFF) begin errors++; $display("FAIL reset_cen: got %h want ffff", CEN); end
        checks++; if (WEN !== 16'hFFFF) begin errors++; $display("FAIL reset_wen: got %h want ffff", WEN); end
        checks++; if (A !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", A); end
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("FAIL reset_valid_last: got %b %b want 0 0", out_valid, out_last);
        end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_sweep();
        fill_ramp();
        sweep(8'd0, 9'd256, 16'hFFFF, 100, -1, 1'b0, 1'b0, 8'd0, 9'd0);
        checks++;
        if (first_valid_cyc != 3) begin errors++; $display("FAIL latency: first valid at %0d want 3", first_valid_cyc); end
        checks++;
        if (last_xfer_cyc - first_xfer_cyc != 255) begin
            errors++; $display("FAIL bubbles: span %0d want 255", last_xfer_cyc - first_xfer_cyc);
        end
    endtask

    task automatic test_wrap();
        fill_ramp();
        sweep(8'd250, 9'd10, 16'hFFFF, 100, -1, 1'b0, 1'b0, 8'd0, 9'd0);
    endtask

    task automatic test_backpressure();
        fill_random();
        sweep(8'($urandom_range(255)), 9'd64, 16'hFFFF, 50, 10, 1'b0, 1'b0, 8'd0, 9'd0);
    endtask

    task automatic test_zero_rows();
        sweep(8'd17, 9'd0, 16'hFFFF, 100, -1, 1'b0, 1'b0, 8'd0, 9'd0);
        checks++;
        if (done_cyc != 0) begin errors++; $display("FAIL zero_rows_done: at %0d want 0", done_cyc); end
    endtask

    task automatic test_back_to_back();
        fill_random();
        sweep(8'd0, 9'd1, 16'hFFFF, 100, -1, 1'b0, 1'b1, 8'd40, 9'd2);
        sweep(8'd40, 9'd2, 16'hFFFF, 100, -1, 1'b1, 1'b0, 8'd0, 9'd0);
    endtask

    task automatic test_reset_mid();
        int got;
        got = 0;
        start = 1'b1; base_addr = 8'd0; num_rows = 9'd64; out_ready = 1'b1;
`ifdef MEM_OUT_READER_BANK_MASK_EN
        bank_en = 16'hFFFF;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            if (out_valid === 1'b1) got++;
            @(posedge clk); #1;
        end
        checks++;
        if (got != 20) begin errors++; $display("FAIL reset_mid_progress: got %0d rows want 20", got); end
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || CEN !== 16'hFFFF || A !== '0 ||
            out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy %b done %b CEN %h valid %b last %b", busy, done, CEN, out_valid, out_last);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_hold: done %b busy %b valid %b", done, busy, out_valid);
            end
        end
        resetn = 1'b1;
        fill_ramp();
        sweep(8'd0, 9'd4, 16'hFFFF, 100, -1, 1'b0, 1'b0, 8'd0, 9'd0);
    endtask

`ifdef MEM_OUT_READER_BANK_MASK_EN
    task automatic test_bank_mask();
        fill_random();
        sweep(8'd3, 9'd8, 16'h00FF, 100, -1, 1'b0, 1'b0, 8'd0, 9'd0);
        sweep(8'd9, 9'd3, 16'h0000, 60, -1, 1'b0, 1'b0, 8'd0, 9'd0);
        bank_en = 16'hFFFF;
    endtask
`endif

    initial begin
        resetn = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b0;
`ifdef MEM_OUT_READER_BANK_MASK_EN
        bank_en = 16'hFFFF;
`endif
        for (int k = 0; k < NB; k++) q_r[k] = '0;
        test_reset();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_zero_rows();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_OUT_READER_BANK_MASK_EN
        test_bank_mask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
